// File: rtl/cpu_bus_ctrl.sv
// Bus sequencer between the CPU execute core and the system bus: runs the
// reset-vector fetch and the NMI/IRQ entry, otherwise forwards core requests.
module cpu_bus_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 16,
    parameter int                CYC_W       = 32,
    parameter int                RESET_DUMMY = 5,
    parameter logic [ADDR_W-1:0] NMI_VEC     = 'hFFFA,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 'hFFFC,
    parameter logic [ADDR_W-1:0] IRQ_VEC     = 'hFFFE,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 'h0100
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] din,
    output logic              rw,
    input  logic              rdy,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              int_poll,
    input  logic              irq_mask,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] p_in,
    input  logic [7:0]        sp_in,
    input  logic              nmi_n,
    input  logic              irq_n,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_value,
    output logic              sp_load,
    output logic [7:0]        sp_value,
    output logic              int_taken,
    output logic              busy,
    output logic [CYC_W-1:0]  cycle
);

    localparam logic [3:0] RST_DUMMY = 4'd0;
    localparam logic [3:0] RST_VL    = 4'd1;
    localparam logic [3:0] RST_VH    = 4'd2;
    localparam logic [3:0] SERVE     = 4'd3;
    localparam logic [3:0] INT_PCH   = 4'd4;
    localparam logic [3:0] INT_PCL   = 4'd5;
    localparam logic [3:0] INT_P     = 4'd6;
    localparam logic [3:0] INT_VL    = 4'd7;
    localparam logic [3:0] INT_VH    = 4'd8;

    // With no dummy cycles configured the sequence starts directly at the vector fetch.
    localparam logic [3:0] RST_FIRST = (RESET_DUMMY > 0) ? RST_DUMMY : RST_VL;
    localparam int DCNT_W = $clog2(RESET_DUMMY + 1) + 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'((RESET_DUMMY > 0) ? RESET_DUMMY - 1 : 0);

    logic [3:0]        state;
    logic [DCNT_W-1:0] dcnt;
    logic              nmi_q;
    logic              nmi_pend;
    logic              vec_nmi;
    logic [ADDR_W-1:0] addr_last;
    logic [ADDR_W-1:0] pc_l;
    logic [DATA_W-1:0] p_l;
    logic [7:0]        sp_l;
    logic [DATA_W-1:0] vl;
    logic              serve;
    logic              irq_act;
    logic              take_int;
    logic              accept;
    logic              nmi_fall;
    logic [ADDR_W-1:0] vec_base;

    function automatic logic [ADDR_W-1:0] push_addr(input logic [7:0] s);
        return STACK_BASE + ADDR_W'(s);
    endfunction

    assign serve     = (state == SERVE);
    assign irq_act   = ~irq_n & ~irq_mask;
    assign take_int  = serve & int_poll & (nmi_pend | irq_act);
    assign accept    = serve & ~take_int & req_valid & (rdy | ~req_rw);
    assign req_ready = accept;
    assign nmi_fall  = nmi_q & ~nmi_n;
    assign vec_base  = vec_nmi ? NMI_VEC : IRQ_VEC;
    assign busy      = ~serve;

    assign pc_load   = ((state == RST_VH) | (state == INT_VH)) & rdy;
    assign sp_load   = pc_load;
    assign int_taken = (state == INT_VH) & rdy;
    assign pc_value  = ADDR_W'({din, vl});
    assign sp_value  = (state == INT_VH) ? sp_l - 8'd3 : 8'hFD;

    always_comb begin
        addr = addr_last;
        rw   = 1'b1;
        dout = '0;
        case (state)
            RST_DUMMY, RST_VL: addr = RESET_VEC;
            RST_VH:            addr = RESET_VEC + ADDR_W'(1);
            INT_PCH: begin
                addr = push_addr(sp_l);
                rw   = 1'b0;
                dout = DATA_W'(pc_l >> DATA_W);
            end
            INT_PCL: begin
                addr = push_addr(sp_l - 8'd1);
                rw   = 1'b0;
                dout = DATA_W'(pc_l);
            end
            INT_P: begin
                addr = push_addr(sp_l - 8'd2);
                rw   = 1'b0;
                dout = p_l;
            end
            INT_VL:            addr = vec_base;
            INT_VH:            addr = vec_base + ADDR_W'(1);
            default: begin
                if (accept) begin
                    addr = req_addr;
                    rw   = req_rw;
                    dout = req_rw ? '0 : req_wdata;
                end
            end
        endcase
    end

    // Read states advance only with rdy; push (write) states never stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_FIRST;
            dcnt       <= '0;
            nmi_q      <= 1'b1;
            nmi_pend   <= 1'b0;
            vec_nmi    <= 1'b0;
            addr_last  <= RESET_VEC;
            resp_valid <= 1'b0;
            cycle      <= '0;
        end else begin
            cycle      <= cycle + CYC_W'(1);
            addr_last  <= addr;
            nmi_q      <= nmi_n;
            resp_valid <= accept & req_rw;
            if ((state == INT_VL) && rdy && vec_nmi)
                nmi_pend <= 1'b0;
            else if (nmi_fall)
                nmi_pend <= 1'b1;
            case (state)
                RST_DUMMY: if (rdy) begin
                    if (dcnt == DCNT_LAST) state <= RST_VL;
                    else                   dcnt  <= dcnt + DCNT_W'(1);
                end
                RST_VL:  if (rdy) state <= RST_VH;
                RST_VH:  if (rdy) state <= SERVE;
                SERVE:   if (take_int) state <= INT_PCH;
                INT_PCH: state <= INT_PCL;
                INT_PCL: state <= INT_P;
                INT_P: begin
                    // An NMI edge landing on this same clock still hijacks the entry.
                    state   <= INT_VL;
                    vec_nmi <= nmi_pend | nmi_fall;
                end
                INT_VL:  if (rdy) state <= INT_VH;
                INT_VH:  if (rdy) state <= SERVE;
                default: state <= RST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (take_int) begin
            pc_l <= pc_in;
            p_l  <= p_in;
            sp_l <= sp_in;
        end
        if (((state == RST_VL) || (state == INT_VL)) && rdy)
            vl <= din;
        if (accept & req_rw)
            resp_rdata <= din;
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: directed reset/interrupt sequences plus
// randomized core read/write traffic against a byte-array reference memory.
module tb_cpu_bus_ctrl;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 16;
    localparam int CYC_W       = 6;
    localparam int RESET_DUMMY = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] din;
    logic              rw;
    logic              rdy;
    logic              req_valid;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              int_poll;
    logic              irq_mask;
    logic [ADDR_W-1:0] pc_in;
    logic [DATA_W-1:0] p_in;
    logic [7:0]        sp_in;
    logic              nmi_n;
    logic              irq_n;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_value;
    logic              sp_load;
    logic [7:0]        sp_value;
    logic              int_taken;
    logic              busy;
    logic [CYC_W-1:0]  cycle;

    always #5 clk = ~clk;

    cpu_bus_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W), .RESET_DUMMY(RESET_DUMMY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .dout(dout), .din(din), .rw(rw),
        .rdy(rdy), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .int_poll(int_poll), .irq_mask(irq_mask),
        .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in), .nmi_n(nmi_n), .irq_n(irq_n),
        .pc_load(pc_load), .pc_value(pc_value), .sp_load(sp_load),
        .sp_value(sp_value), .int_taken(int_taken), .busy(busy), .cycle(cycle)
    );

    typedef struct {
        int          cyc;
        logic [15:0] pc;
        logic [7:0]  sp;
        logic        sl;
        logic        it;
    } load_t;

    load_t       load_q[$];
    logic [23:0] wr_q[$];
    logic [7:0]  bus_mem [0:65535];
    logic [7:0]  ref_mem [0:15];
    logic [15:0] nvec;
    logic [15:0] ivec;
    int          tcyc = 0;
    int          checks = 0;
    int          errors = 0;

    // System memory: fixed vectors, one fixed read location, the rest written by the DUT.
    always_comb begin
        if (!rdy) din = 8'hEE;
        else begin
            case (addr)
                16'hFFFC: din = 8'h34;
                16'hFFFD: din = 8'h12;
                16'hFFFA: din = nvec[7:0];
                16'hFFFB: din = nvec[15:8];
                16'hFFFE: din = ivec[7:0];
                16'hFFFF: din = ivec[15:8];
                16'h0200: din = 8'hAB;
                default:  din = bus_mem[addr];
            endcase
        end
    end

    always @(posedge clk) tcyc <= tcyc + 1;

    always @(negedge clk) begin
        load_t e;
        if (!rw) begin
            wr_q.push_back({addr, dout});
            bus_mem[addr] = dout;
        end
        if (pc_load) begin
            e.cyc = tcyc;
            e.pc  = pc_value;
            e.sp  = sp_value;
            e.sl  = sp_load;
            e.it  = int_taken;
            load_q.push_back(e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_load(input int base, input int maxc, input string tag);
        int n;
        n = 0;
        while (load_q.size() <= base && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, " load seen"}, 32'(load_q.size() > base), 32'd1);
    endtask

    function automatic load_t load_at(input int i);
        load_t e;
        e.cyc = -1; e.pc = '1; e.sp = '1; e.sl = 1'b0; e.it = 1'b0;
        if (i < load_q.size()) e = load_q[i];
        return e;
    endfunction

    function automatic logic [23:0] wr_at(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 24'hFFFFFF;
    endfunction

    initial begin
        int          t0, tp, bw, bl, s;
        logic [15:0] a;
        logic [7:0]  d;
        bit          wr;
        load_t       e;

        nvec = {8'h9A, 8'($urandom)};
        ivec = {8'hE0, 8'($urandom)};
        rdy = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = '0; req_wdata = '0;
        int_poll = 1'b0; irq_mask = 1'b1; pc_in = '0; p_in = '0; sp_in = '0;
        nmi_n = 1'b1; irq_n = 1'b1; rst_n = 1'b0;
        tickn(2);

        chk("rst rw", 32'(rw), 32'd1);
        chk("rst addr", 32'(addr), 32'hFFFC);
        chk("rst dout", 32'(dout), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst loads", 32'({pc_load, sp_load, int_taken}), 32'd0);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst cycle", 32'(cycle), 32'd0);
        req_valid = 1'b0;

        // Reset-vector fetch
        rst_n = 1'b1;
        t0 = tcyc;
        bl = load_q.size();
        wait_load(bl, 20, "reset");
        e = load_at(bl);
        chk("reset latency", 32'(e.cyc - t0 + 1), 32'(RESET_DUMMY + 2));
        chk("reset pc", 32'(e.pc), 32'h1234);
        chk("reset sp", 32'({e.sl, e.sp}), 32'h1FD);
        chk("reset no int_taken", 32'(e.it), 32'd0);
        @(negedge clk);
        chk("serve not busy", 32'(busy), 32'd0);

        // Directed SERVE read then write
        tick();
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0200;
        @(negedge clk);
        chk("rd accept", 32'({req_ready, rw, addr}), 32'h30200);
        tick();
        req_rw = 1'b0; req_addr = 16'h0300; req_wdata = 8'h5A;
        @(negedge clk);
        chk("rd resp", 32'({resp_valid, resp_rdata}), 32'h1AB);
        chk("wr bus", 32'({req_ready, rw, addr, dout}), 32'h203005A);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("wr no resp", 32'(resp_valid), 32'd0);
        chk("idle hold", 32'({rw, addr}), 32'h10300);

        // Random core traffic: first fill the window, then mix reads/writes with read stalls
        for (int i = 0; i < 56; i++) begin
            tick();
            a  = 16'h0400 + 16'((i < 16) ? i : $urandom_range(0, 15));
            wr = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            s  = wr ? 0 : $urandom_range(0, 2);
            req_valid = 1'b1; req_rw = ~wr; req_addr = a; req_wdata = d; rdy = (s == 0);
            for (int j = 0; j < s; j++) begin
                @(negedge clk);
                chk("stall no accept", 32'({req_ready, rw}), 32'd1);
                tick();
            end
            rdy = 1'b1;
            @(negedge clk);
            chk("rnd accept", 32'(req_ready), 32'd1);
            if (wr) begin
                chk("rnd wr bus", 32'({rw, addr, dout}), 32'({1'b0, a, d}));
                ref_mem[a[3:0]] = d;
            end else begin
                chk("rnd rd bus", 32'({rw, addr}), 32'({1'b1, a}));
            end
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            chk("rnd resp_valid", 32'(resp_valid), 32'(!wr));
            if (!wr) chk("rnd rdata", 32'(resp_rdata), 32'(ref_mem[a[3:0]]));
            chk("rnd idle hold", 32'({rw, addr}), 32'({1'b1, a}));
        end
        chk("cycle wrap", 32'(cycle), 32'(6'(tcyc - t0)));

        // IRQ entry, concurrent core read must be refused on the poll cycle
        tick();
        bw = wr_q.size(); bl = load_q.size();
        irq_mask = 1'b0; irq_n = 1'b0; pc_in = 16'hC123; p_in = 8'h24; sp_in = 8'hFD;
        int_poll = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0200;
        @(negedge clk);
        tp = tcyc;
        chk("irq poll req_ready", 32'(req_ready), 32'd0);
        tick();
        int_poll = 1'b0; req_valid = 1'b0;
        chk("irq busy", 32'(busy), 32'd1);
        wait_load(bl, 20, "irq");
        e = load_at(bl);
        chk("irq latency", 32'(e.cyc - tp), 32'd5);
        chk("irq push pch", 32'(wr_at(bw)), 32'h01FDC1);
        chk("irq push pcl", 32'(wr_at(bw + 1)), 32'h01FC23);
        chk("irq push p", 32'(wr_at(bw + 2)), 32'h01FB24);
        chk("irq push count", 32'(wr_q.size() - bw), 32'd3);
        chk("irq pc", 32'(e.pc), 32'(ivec));
        chk("irq sp", 32'({e.sl, e.it, e.sp}), 32'h3FA);
        irq_n = 1'b1; irq_mask = 1'b1;

        // IRQ entry hijacked by an NMI edge during the PCL push
        tick();
        bw = wr_q.size(); bl = load_q.size();
        irq_mask = 1'b0; irq_n = 1'b0; pc_in = 16'h8421; p_in = 8'hA5; sp_in = 8'hF0;
        int_poll = 1'b1;
        @(negedge clk);
        tp = tcyc;
        tick();
        int_poll = 1'b0;
        tick();
        nmi_n = 1'b0;
        wait_load(bl, 20, "hijack");
        e = load_at(bl);
        chk("hijack latency", 32'(e.cyc - tp), 32'd5);
        chk("hijack pc", 32'(e.pc), 32'(nvec));
        chk("hijack sp", 32'({e.it, e.sp}), 32'h1ED);
        chk("hijack push p", 32'(wr_at(bw + 2)), 32'h01EEA5);
        irq_n = 1'b1;
        tick();
        int_poll = 1'b1;
        tick();
        int_poll = 1'b0;
        tickn(8);
        chk("no second entry", 32'(load_q.size() - bl), 32'd1);
        chk("no second entry busy", 32'(busy), 32'd0);
        nmi_n = 1'b1;

        // Masked IRQ is ignored
        tick();
        bw = wr_q.size(); bl = load_q.size();
        irq_mask = 1'b1; irq_n = 1'b0; int_poll = 1'b1;
        tick();
        int_poll = 1'b0;
        chk("masked busy", 32'(busy), 32'd0);
        tickn(8);
        chk("masked no entry", 32'({16'(load_q.size() - bl), 16'(wr_q.size() - bw)}), 32'd0);
        irq_n = 1'b1;

        // NMI with sp=0x01: pushes wrap in the stack page, writes ignore rdy
        tick();
        nmi_n = 1'b0;
        tick();
        bw = wr_q.size(); bl = load_q.size();
        pc_in = 16'hBEEF; p_in = 8'h30; sp_in = 8'h01; int_poll = 1'b1;
        @(negedge clk);
        tp = tcyc;
        tick();
        int_poll = 1'b0; rdy = 1'b0;
        tickn(3);
        rdy = 1'b1;
        wait_load(bl, 20, "nmi");
        e = load_at(bl);
        chk("nmi latency", 32'(e.cyc - tp), 32'd5);
        chk("nmi push pch", 32'(wr_at(bw)), 32'h0101BE);
        chk("nmi push pcl", 32'(wr_at(bw + 1)), 32'h0100EF);
        chk("nmi push p", 32'(wr_at(bw + 2)), 32'h01FF30);
        chk("nmi pc", 32'(e.pc), 32'(nvec));
        chk("nmi sp", 32'({e.it, e.sp}), 32'h1FE);
        nmi_n = 1'b1;

        // Asynchronous reset, then abort during the vector-high read
        tick();
        rst_n = 1'b0;
        #1;
        chk("async rst", 32'({busy, rw, addr, cycle}), 32'({1'b1, 1'b1, 16'hFFFC, 6'd0}));
        tickn(2);
        rst_n = 1'b1;
        bl = load_q.size();
        tickn(RESET_DUMMY + 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort no load", 32'(load_q.size() - bl), 32'd0);
        tick();

        // Read stall during the reset vector-low fetch
        rst_n = 1'b1;
        t0 = tcyc;
        bl = load_q.size();
        tickn(RESET_DUMMY);
        rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall vl addr", 32'({pc_load, rw, addr}), 32'h1FFFC);
            tick();
        end
        rdy = 1'b1;
        wait_load(bl, 20, "stall reset");
        e = load_at(bl);
        chk("stall reset latency", 32'(e.cyc - t0 + 1), 32'(RESET_DUMMY + 5));
        chk("stall reset pc", 32'(e.pc), 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Parametrised bus sequencer between the CPU execute core and the system bus. It replaces the core's direct inout bus with a separated read/write bus and a RDY stall input, and adds a cycle counter. It owns the bus during two hardware sequences: the reset-vector fetch and the NMI/IRQ entry (three stack pushes plus the vector fetch). Outside those sequences it forwards single-cycle read/write requests from the execute core.

## Interface
Parameters:
- DATA_W, 8, bus data width
- ADDR_W, 16, bus address width
- CYC_W, 32, cycle counter width
- RESET_DUMMY, 5, dummy read cycles before reset vector fetch (≥0)
- NMI_VEC / RESET_VEC / IRQ_VEC, 'hFFFA / 'hFFFC / 'hFFFE, vector low-byte addresses (high byte at +1)
- STACK_BASE, 'h0100, stack page base; push address = STACK_BASE + sp

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr  out  ADDR_W  bus address
- dout  out  DATA_W  bus write data
- din  in  DATA_W  bus read data, sampled on rising edge
- rw  out  1  1 = read, 0 = write
- rdy  in  1  0 stalls read cycles
- req_valid  in  1  core bus request
- req_rw  in  1  request direction (1 = read)
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  request write data
- req_ready  out  1  request accepted this cycle
- resp_valid  out  1  read data valid (1-cycle pulse)
- resp_rdata  out  DATA_W  read data
- int_poll  in  1  core at instruction boundary (1-cycle pulse)
- irq_mask  in  1  core I flag
- pc_in  in  ADDR_W  return PC to push
- p_in  in  DATA_W  status byte to push
- sp_in  in  8  stack pointer at int_poll
- nmi_n, irq_n  in  1  interrupt lines (pre-synchronised)
- pc_load / pc_value  out  1 / ADDR_W  load core PC (1-cycle pulse)
- sp_load / sp_value  out  1 / 8  load core SP (1-cycle pulse)
- int_taken  out  1  pulse with pc_load of an interrupt entry; also asserts core I flag
- busy  out  1  sequencer owns the bus
- cycle  out  CYC_W  free-running cycle count

## Operation
- States: RST_DUMMY → RST_VL → RST_VH → SERVE → (INT_PCH → INT_PCL → INT_P → INT_VL → INT_VH) → SERVE.
- RST_DUMMY: RESET_DUMMY read cycles, addr=RESET_VEC. RST_VL/RST_VH read RESET_VEC/+1. On the RST_VH completing edge: pc_load=1, pc_value={din, VL}, sp_load=1, sp_value='hFD.
- SERVE: req_ready = req_valid & (rdy | ~req_rw). On an accepted request, addr=req_addr, rw=req_rw, dout=req_wdata (combinational). A read gives resp_valid and resp_rdata=din on the next cycle. With no request: rw=1, addr holds its last value.
- NMI: falling edge of nmi_n sets nmi_pend. nmi_pend clears on the INT_VL cycle that uses NMI_VEC.
- IRQ is level-sensitive: irq_n=0 & ~irq_mask.
- On int_poll in SERVE with nmi_pend or IRQ asserted: enter INT_PCH, latch pc_in/p_in/sp_in, deassert req_ready.
- Pushes are writes: PCH at STACK_BASE+sp, PCL at +sp-1, P at +sp-2.
- Vector select happens at INT_VL entry: NMI_VEC if nmi_pend, else IRQ_VEC. An NMI edge arriving during the pushes hijacks an IRQ entry.
- Completing edge of INT_VH: pc_load, pc_value={din, VL}, sp_load, sp_value=sp-3 (mod 256), int_taken.
- busy=1 in every state except SERVE.

## Timing
- Reset values: rw=1, addr=RESET_VEC, dout=0, req_ready=0, resp_valid=0, pc_load=0, sp_load=0, int_taken=0, busy=1, cycle=0, nmi_pend=0, state RST_DUMMY.
- Reset is fully asynchronous. Asserting rst_n mid-sequence aborts it with no pc_load.
- cycle increments every clock after reset, including stall cycles, and wraps at 2^CYC_W.
- rdy=0 during a read cycle (any state): state, addr and rw hold, and din is ignored. Write cycles (INT_PCH/PCL/P, SERVE writes) ignore rdy.
- Latency: reset to pc_load is RESET_DUMMY+2 cycles. int_poll to pc_load is 5 cycles plus read stalls. SERVE read to resp_valid is 1 cycle.
- Stack push addresses wrap within the page: sp=0x01 pushes at 0x0101, 0x0100, 0x01FF.
- int_poll outside SERVE is ignored. int_poll with nothing pending does nothing.
- nmi_n falling while nmi_pend=1: no additional pending NMI.

## Test plan
- Reset, din=0x34 at 0xFFFC, 0x12 at 0xFFFD, rdy=1 → pc_load with pc_value=0x1234 exactly 7 cycles after rst_n rises; sp_value=0xFD.
- SERVE read 0x0200 (din=0xAB) then write 0x0300←0x5A → resp_valid with 0xAB one cycle later; rw=0, dout=0x5A, addr=0x0300 during the write.
- irq_n=0, irq_mask=0, pc_in=0xC123, p_in=0x24, sp_in=0xFD, int_poll → writes 0xC1@0x01FD, 0x23@0x01FC, 0x24@0x01FB; reads 0xFFFE/F; sp_value=0xFA; int_taken.
- IRQ entry with nmi_n falling during INT_PCL → vector reads at 0xFFFA/B, nmi_pend cleared afterwards, no second entry.
- rdy=0 for 3 cycles during RST_VL → addr stays 0xFFFC; pc_load delayed by 3; writes during an interrupt entry with rdy=0 are not stalled.
- irq_mask=1 with irq_n=0 → no entry; sp_in=0x01 NMI entry → pushes at 0x0101, 0x0100, 0x01FF; sp_value=0xFE.
